// File: rtl/mux_arb_pkg.sv
// Shared widths, FSM state type and round-robin search for the 4-way arbitrated mux.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Pick the first active requester after 'last', wrapping 3 -> 0.
  // If nothing is requesting, 'last' comes back unchanged; callers gate on |req.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// 4:1 data mux steered by the arbiter's registered owner index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows sel and inputs.
module mux_rr_arbiter_mux4
  import mux_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] y
);

  // Select one requester's data by index.
  always_comb begin
    y = a;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter over 4 requesters with burst cap, driving a 4:1 data mux.
// Latency: grant one cycle after request seen in IDLE; one idle bubble after every release.
// Backpressure: out_ready low freezes the burst (owner, count, data) with no timeout.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  c,
  input  logic [DATA_W-1:0]  d,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  y,
  output logic               out_valid
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0]   last_owner_q, last_owner_d;
  logic [SEL_W-1:0]   winner;

  // State register; reset leaves last_owner at 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      gnt_q        <= '0;
      beat_cnt_q   <= '0;
      last_owner_q <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    out_valid    = 1'b0;
    winner       = rr_pick(req, last_owner_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d      = winner;
          gnt_d      = NUM_REQ'(1) << winner;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        out_valid = req[sel_q];
        // Owner dropping its request, or finishing its last allowed beat, releases.
        if (!req[sel_q] || (out_ready && beat_cnt_q == LAST_BEAT)) begin
          state_d      = IDLE;
          gnt_d        = '0;
          beat_cnt_d   = '0;
          last_owner_d = sel_q;
        end else if (out_ready) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

  mux_rr_arbiter_mux4 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel_q),
    .y   (y)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for the round-robin arbitrated mux: a default-burst and a single-beat instance.
// Expected per-cycle grant/valid/data pushed at stimulus time, popped each falling edge.
// Inputs change on falling edges only, so every check sees settled state.
module tb_mux_rr_arbiter;

  localparam logic [3:0] DA = 4'h1;
  localparam logic [3:0] DB = 4'h2;
  localparam logic [3:0] DC = 4'hA;
  localparam logic [3:0] DD = 4'h4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a, b, c, d;
  logic       out_ready;
  logic [3:0] gnt0, y0, gnt1, y1;
  logic [1:0] sel0, sel1;
  logic       ov0, ov1;

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [3:0] y;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   tgt   = 1'b0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_BURST(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt0), .sel(sel0), .y(y0), .out_valid(ov0)
  );

  mux_rr_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt1), .sel(sel1), .y(y1), .out_valid(ov1)
  );

  function automatic logic [3:0] dv(input int i);
    case (i)
      0:       return DA;
      1:       return DB;
      2:       return DC;
      default: return DD;
    endcase
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic v, input int yi);
    sbq.push_back({g, v, dv(yi)});
  endtask

  // Pop one expectation per falling edge and compare against the selected instance.
  task automatic consume(input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s:sb_empty observed=empty expected=entry", tag);
      end else begin
        e = sbq.pop_front();
        chk({tag, ":gnt"}, 8'(tgt ? gnt1 : gnt0), 8'(e.gnt));
        chk({tag, ":vld"}, 8'(tgt ? ov1 : ov0), 8'(e.vld));
        chk({tag, ":y"},   8'(tgt ? y1 : y0), 8'(e.y));
        if (e.gnt != 4'b0000)
          chk({tag, ":sel"}, 8'(tgt ? sel1 : sel0), 8'(enc(e.gnt)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    a = DA; b = DB; c = DC; d = DD;

    // Reset values
    #12;
    chk("rst:gnt0", 8'(gnt0), 8'h0);
    chk("rst:sel0", 8'(sel0), 8'h0);
    chk("rst:vld0", 8'(ov0), 8'h0);
    chk("rst:gnt1", 8'(gnt1), 8'h0);

    @(negedge clk); rst_n = 1'b1;
    push(4'b0000, 1'b0, 0);
    consume(1, "post_rst_idle");

    // All requesting: 0,1,2,3,0 with 4 beats each and an idle bubble between
    req = 4'b1111; out_ready = 1'b1;
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 4; k++) push(4'(1 << o), 1'b1, o);
      push(4'b0000, 1'b0, o);
    end
    push(4'b0001, 1'b1, 0);
    consume(21, "rr_all");
    req = 4'b0000;
    push(4'b0000, 1'b0, 0);
    consume(1, "rr_all_rel");

    // Only requester 2: granted one cycle later with its data
    req = 4'b0100;
    push(4'b0100, 1'b1, 2);
    consume(1, "c_only");
    req = 4'b0000;
    push(4'b0000, 1'b0, 2);
    consume(1, "c_only_rel");

    // Owner 1 stalled by out_ready low, then finishes its 4 beats
    req = 4'b0010; out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(4'b0010, 1'b1, 1);
    consume(6, "stall");
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(4'b0010, 1'b1, 1);
    push(4'b0000, 1'b0, 1);
    consume(4, "stall_rel");
    req = 4'b0000;
    push(4'b0000, 1'b0, 1);
    consume(1, "stall_idle");

    // Owner 2 drops after 2 beats; next winner from 4'b1001 is 3
    req = 4'b0100; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(4'b0100, 1'b1, 2);
    consume(3, "drop");
    req = 4'b0000;
    #1;
    chk("drop:vld_now", 8'(ov0), 8'h0);
    push(4'b0000, 1'b0, 2);
    consume(1, "drop_idle");
    req = 4'b1001;
    push(4'b1000, 1'b1, 3);
    consume(1, "after_drop");
    req = 4'b0000;
    push(4'b0000, 1'b0, 3);
    consume(1, "after_drop_rel");

    // Reset pulse mid-burst of owner 1 clears grant at once
    req = 4'b0010; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) push(4'b0010, 1'b1, 1);
    consume(2, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst:gnt", 8'(gnt0), 8'h0);
    chk("mid_rst:vld", 8'(ov0), 8'h0);
    chk("mid_rst:sel", 8'(sel0), 8'h0);
    req = 4'b0000;
    @(negedge clk); rst_n = 1'b1;
    push(4'b0000, 1'b0, 0);
    consume(1, "rst_rel_idle");
    req = 4'b0011;
    push(4'b0001, 1'b1, 0);
    consume(1, "rst_win");
    req = 4'b0000;
    push(4'b0000, 1'b0, 0);
    consume(1, "rst_win_rel");

    // Single-beat bursts alternate 0,1,0,1 with a bubble between
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tgt = 1'b1;
    push(4'b0000, 1'b0, 0);
    consume(1, "b1_idle");
    req = 4'b0011; out_ready = 1'b1;
    push(4'b0001, 1'b1, 0); push(4'b0000, 1'b0, 0);
    push(4'b0010, 1'b1, 1); push(4'b0000, 1'b0, 1);
    push(4'b0001, 1'b1, 0); push(4'b0000, 1'b0, 0);
    push(4'b0010, 1'b1, 1);
    consume(7, "burst1");
    req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
